mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are 4 to 64.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an operation, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits, selecting the operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each: the multiplicand/dividend and multiplier/divisor.
REQ-007 The block SHALL have port flush, input, 1 bit, a synchronous abort of an operation in progress.
REQ-008 The block SHALL have ports hi_we and lo_we, inputs, 1 bit each: direct writes of HI and LO (MTHI/MTLO).
REQ-009 The block SHALL have port wdata, input, WIDTH bits, the data for hi_we and lo_we.
REQ-010 The block SHALL have ports hi and lo, outputs, WIDTH bits each, driven by registers.
REQ-011 The block SHALL have port busy, output, 1 bit, high while in BUSY.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-013 The block SHALL have port div0, output, 1 bit, a divide-by-zero flag, valid only while done is high.

Function
REQ-014 The block SHALL use an FSM with states IDLE, BUSY and FINISH.
REQ-015 IDLE with start=1 SHALL latch a, b and op on that edge and move to BUSY; the iteration counter SHALL be loaded with WIDTH.
REQ-016 BUSY SHALL perform exactly one iteration per cycle and SHALL move to FINISH when the counter reaches 0, i.e. after WIDTH cycles.
REQ-017 FINISH SHALL last one cycle: hi and lo are updated, done=1, then the FSM returns to IDLE.
REQ-018 done SHALL rise exactly WIDTH+1 cycles after the edge that accepts start.
REQ-019 A new start SHALL be accepted in the cycle immediately after done.
REQ-020 Multiplication SHALL be iterative shift-add on operand magnitudes.
REQ-021 For MULT, the 2*WIDTH product SHALL be negated when the operand signs differ.
REQ-022 Multiplication results: hi = product[2W-1:W], lo = product[W-1:0].
REQ-023 Division SHALL be iterative restoring division on operand magnitudes.
REQ-024 For DIV, the quotient SHALL be negated when the signs differ, and the remainder SHALL take the sign of the dividend.
REQ-025 Division results: lo = quotient, hi = remainder.
REQ-026 Signed overflow, DIV with a = most-negative value and b = -1, SHALL give lo = a and hi = 0, with no flag.
REQ-027 Divide-by-zero (b = 0, DIV or DIVU) SHALL still take the full latency and then give lo = all ones, hi = a, div0 = 1.
REQ-028 For all other operations div0 SHALL be 0.
REQ-029 busy SHALL be 1 in BUSY and in FINISH.
REQ-030 start while busy=1 SHALL be ignored; it is neither queued nor an error.
REQ-031 Changes to a, b and op after acceptance SHALL have no effect on the running operation.
REQ-032 flush=1 in BUSY or FINISH SHALL return the FSM to IDLE on the next edge, with no done pulse and hi/lo unchanged; flush in IDLE SHALL have no effect.
REQ-033 flush SHALL take priority over start in the same cycle.
REQ-034 hi_we/lo_we SHALL write wdata into hi/lo only while busy=0; writes while busy=1 SHALL be dropped.
REQ-035 If start and hi_we/lo_we occur in the same IDLE cycle, both SHALL take effect; the write lands now and the operation result overwrites it at FINISH.
REQ-036 hi and lo SHALL change only on a FINISH cycle, an accepted write, or reset.

Reset
REQ-037 reset=0 SHALL asynchronously force the FSM to IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0 and div0 = 0.
REQ-038 Reset asserted mid-operation SHALL discard the operation; no done pulse SHALL follow the release of reset.
REQ-039 The first start SHALL be accepted on the first rising edge after reset is released.

Verification (WIDTH=32)
REQ-040 Bench SHALL check: MULT a=FFFFFFFD, b=00000007 -> done 33 cycles after start, hi=FFFFFFFF, lo=FFFFFFEB, div0=0.
REQ-041 Bench SHALL check: MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-042 Bench SHALL check: DIV a=FFFFFFF9, b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; then DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-043 Bench SHALL check: DIVU a=00000064, b=0 -> done after 33 cycles, div0=1, lo=FFFFFFFF, hi=00000064.
REQ-044 Bench SHALL check: hi=lo=12345678, start MULTU 3x5, flush at cycle 10 -> no done, hi/lo still 12345678; restart in the next cycle -> lo=0000000F after 33 cycles.
REQ-045 Bench SHALL check: reset low at cycle 20 of a DIVU -> all outputs 0 immediately, no done afterwards; start plus lo_we=1, wdata=AAAAAAAA in IDLE -> lo=AAAAAAAA next cycle, then overwritten at done; lo_we during busy -> lo unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: one shift-add or
// restoring-division step per cycle, done pulses WIDTH+1 cycles after start.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FINISH} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, div0_q, div0_d;

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, add, shifted, diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply datapath: acc_q:q_q is the partial product, q_q[0] the next multiplier bit.
  assign sum     = acc_q + {1'b0, m_q};
  assign add     = q_q[0] ? sum : acc_q;

  // Divide datapath: acc_q is the partial remainder, q_q shifts dividend out and quotient in.
  assign shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, m_q};
  assign ge      = shifted >= {1'b0, m_q};

  always_comb begin
    prod = {acc_q[WIDTH-1:0], q_q};
    if (op_q == OP_MULT && (sa_q ^ sb_q)) prod = -prod;
    quo = q_q;
    rem = acc_q[WIDTH-1:0];
    if (op_q == OP_DIV) begin
      if (sa_q ^ sb_q) quo = -quo;
      if (sa_q)        rem = -rem;
    end
    if (m_q == '0) quo = '1;
  end

  // NOTE: every _d gets a default first so no path through the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;

    // Direct writes go first so a FINISH in the same cycle would win; busy_q blocks them in BUSY/FINISH anyway.
    if (!busy_q) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          op_d    = op;
          sa_d    = signed_op & a[WIDTH-1];
          sb_d    = signed_op & b[WIDTH-1];
          acc_d   = '0;
          if (op[1]) begin
            m_d = mag_b;
            q_d = mag_a;
          end else begin
            m_d = mag_a;
            q_d = mag_b;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          if (op_q[1]) begin
            acc_d = ge ? diff : shifted;
            q_d   = {q_q[WIDTH-2:0], ge};
          end else begin
            acc_d = {1'b0, add[WIDTH:1]};
            q_d   = {add[0], q_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!flush) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            hi_d   = rem;
            lo_d   = quo;
            div0_d = (m_q == '0);
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32: expected HI/LO/div0 and the
// acceptance cycle are queued at start and compared when done pulses.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int LATENCY = W + 1;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic         clock, reset, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata, hi, lo;
  logic         busy, done, div0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic on 64-bit integers; C-style truncating division.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, sq, sr;
    logic [63:0] ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    e.div0 = 1'b0;
    e.acc_cyc = 0;
    case (o)
      MULT:  begin up = 64'(sx * sy); e.hi = up[63:32]; e.lo = up[31:0]; end
      MULTU: begin up = ux * uy;      e.hi = up[63:32]; e.lo = up[31:0]; end
      default: begin
        if (y == '0) begin
          e.hi = x; e.lo = '1; e.div0 = 1'b1;
        end else if (o == DIV) begin
          sq = sx / sy; sr = sx % sy;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end else begin
          up = ux / uy; e.lo = up[31:0];
          up = ux % uy; e.hi = up[31:0];
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("latency", 64'(cyc - e.acc_cyc), 64'(LATENCY));
        check("hi", {32'h0, hi}, {32'h0, e.hi});
        check("lo", {32'h0, lo}, {32'h0, e.lo});
        check("div0", {63'h0, div0}, {63'h0, e.div0});
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic do_start(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit push, input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = ~x; b = $urandom; op = ~o;
    check("busy_after_start", {63'h0, busy}, 64'h1);
    if (push) begin
      e.hi = eh; e.lo = el; e.div0 = ed; e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic run_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(o, x, y);
    do_start(o, x, y, 1'b1, e.hi, e.lo, e.div0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3 * LATENCY; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clock);
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 64'(sb_q.size()), 0);
      sb_q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    #1;
    check("rst_hi", {32'h0, hi}, 0);
    check("rst_lo", {32'h0, lo}, 0);
    check("rst_busy", {63'h0, busy}, 0);
    check("rst_done", {63'h0, done}, 0);
    check("rst_div0", {63'h0, div0}, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // First edge after reset release accepts; a start while busy is ignored.
    do_start(MULT, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    repeat (5) @(negedge clock);
    start = 1'b1; op = DIVU; a = 32'h5; b = 32'h0;
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    do_start(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_idle();
    do_start(DIV, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_idle();
    do_start(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0);
    wait_idle();
    do_start(DIVU, 32'h00000064, 32'h00000000, 1'b1, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    wait_idle();

    // Back-to-back: second start driven during the done cycle.
    do_start(MULT, 32'h00000006, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
    repeat (LATENCY) @(negedge clock);
    check("done_in_b2b", {63'h0, done}, 64'h1);
    do_start(DIVU, 32'h000003E8, 32'h00000007, 1'b1, 32'h00000006, 32'h0000008E, 1'b0);
    wait_idle();

    // Flush mid-operation leaves HI/LO alone; a direct write while busy is dropped.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_hi", {32'h0, hi}, 64'h12345678);
    check("mt_lo", {32'h0, lo}, 64'h12345678);
    do_start(MULTU, 32'h3, 32'h5, 1'b0, '0, '0, 1'b0);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", {63'h0, busy}, 0);
    check("flush_hi", {32'h0, hi}, 64'h12345678);
    check("flush_lo", {32'h0, lo}, 64'h12345678);
    do_start(MULTU, 32'h3, 32'h5, 1'b1, 32'h0, 32'h0000000F, 1'b0);
    repeat (4) @(negedge clock);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("busy_we_hi", {32'h0, hi}, 64'h12345678);
    check("busy_we_lo", {32'h0, lo}, 64'h12345678);
    wait_idle();

    // Asynchronous reset mid-divide, then silence.
    do_start(DIVU, 32'h000F4240, 32'h00000007, 1'b0, '0, '0, 1'b0);
    repeat (19) @(negedge clock);
    reset = 1'b0;
    #1;
    check("arst_hi", {32'h0, hi}, 0);
    check("arst_lo", {32'h0, lo}, 0);
    check("arst_busy", {63'h0, busy}, 0);
    check("arst_done", {63'h0, done}, 0);
    check("arst_div0", {63'h0, div0}, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2 * LATENCY) @(negedge clock);

    // Start and lo write in the same IDLE cycle; the result overwrites at done.
    lo_we = 1'b1; wdata = 32'hAAAAAAAA;
    do_start(MULTU, 32'h6, 32'h7, 1'b1, 32'h0, 32'h0000002A, 1'b0);
    check("same_cycle_lo", {32'h0, lo}, 64'hAAAAAAAA);
    lo_we = 1'b1; wdata = 32'h55555555;
    @(negedge clock);
    lo_we = 1'b0;
    check("busy_lo_we", {32'h0, lo}, 64'hAAAAAAAA);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i % 4 == 3) ? '0 : ((i % 2 == 0) ? W'($urandom_range(1, 255)) : $urandom);
      if (i % 4 == 1) y = -y;
      run_model(o, x, y);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
